// File: rtl/xadc_mon_pkg.sv
// Shared types and constants for the XADC PWM monitor.
// Holds the DRP bus widths, the default auxiliary-channel DRP addresses
// and the sequencer state encoding used by xadc_pwm_monitor.
package xadc_mon_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;

  // Default auxiliary-channel DRP status register addresses
  localparam logic [DRP_ADDR_W-1:0] AUX_ADDR_CH0 = 7'h1E;
  localparam logic [DRP_ADDR_W-1:0] AUX_ADDR_CH1 = 7'h17;
  localparam logic [DRP_ADDR_W-1:0] AUX_ADDR_CH2 = 7'h1F;
  localparam logic [DRP_ADDR_W-1:0] AUX_ADDR_CH3 = 7'h16;

  // Packed address table, channel 0 in the least significant bits
  localparam logic [4*DRP_ADDR_W-1:0] DEFAULT_CH_ADDR =
    {AUX_ADDR_CH3, AUX_ADDR_CH2, AUX_ADDR_CH1, AUX_ADDR_CH0};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } mon_state_t;

endpackage

// File: rtl/xadc_pwm_monitor_pwm_gen.sv
// pwm_gen: one LED channel of the monitor.
// The duty value is only taken from the sample at counter zero so a new
// sample never changes the pulse width in the middle of a PWM period.
module pwm_gen
  import xadc_mon_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] i_cnt,
  input  logic [PWM_W-1:0] i_sample,
  output logic             o_led
);

  logic [PWM_W-1:0] r_duty;

  // Latch the new duty at the start of each PWM period
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty <= '0;
    end else if (i_cnt == '0) begin
      r_duty <= i_sample;
    end
  end

  assign o_led = (i_cnt < r_duty);

endmodule

// File: rtl/xadc_pwm_monitor.sv
// xadc_pwm_monitor: sequences DRP reads of the XADC auxiliary channels on
// every end-of-conversion, keeps the top PWM_W bits of each result and
// drives one PWM LED per channel from the stored value.
// Optional feature: define XADC_MON_AVG_EN to average four samples per
// channel before a stored value (and sample_valid) is updated.
module xadc_pwm_monitor
  import xadc_mon_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PWM_W   = 8,
  parameter int TIMEOUT = 255,
  parameter logic [DRP_ADDR_W*NUM_CH-1:0] CH_ADDR = DEFAULT_CH_ADDR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    eoc,
  output logic                    drp_den,
  output logic                    drp_dwe,
  output logic [DRP_ADDR_W-1:0]   drp_daddr,
  output logic [DRP_DATA_W-1:0]   drp_di,
  input  logic [DRP_DATA_W-1:0]   drp_do,
  input  logic                    drp_drdy,
  output logic [NUM_CH-1:0]       led,
  output logic [NUM_CH*PWM_W-1:0] data,
  output logic                    sample_valid,
  output logic [3:0]              sample_ch,
  output logic                    err
);

  localparam int TMR_W = 10;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [3:0]       IDX_LAST = 4'(NUM_CH - 1);

  mon_state_t                r_state;
  logic [3:0]                r_idx;
  logic [TMR_W-1:0]          r_waitCnt;
  logic                      r_den;
  logic [DRP_ADDR_W-1:0]     r_daddr;
  logic [NUM_CH*PWM_W-1:0]   r_data;
  logic                      r_sampleValid;
  logic [3:0]                r_sampleCh;
  logic                      r_err;
  logic [PWM_W-1:0]          r_pwmCnt;

  logic [PWM_W-1:0]          w_sample;
  logic [3:0]                w_idxNext;
  logic                      w_unusedDoBits;

  assign w_sample       = drp_do[DRP_DATA_W-1 -: PWM_W];
  assign w_unusedDoBits = ^drp_do[DRP_DATA_W-PWM_W-1:0];
  assign w_idxNext      = (r_idx == IDX_LAST) ? 4'd0 : r_idx + 4'd1;

`ifdef XADC_MON_AVG_EN
  logic [NUM_CH*(PWM_W+2)-1:0] r_acc;
  logic [NUM_CH*2-1:0]         r_avgCnt;
  logic [PWM_W+1:0]            w_accCur;
  logic [PWM_W+1:0]            w_accSum;
  logic [1:0]                  w_avgCntCur;

  assign w_accCur    = r_acc[(PWM_W+2)*int'(r_idx) +: (PWM_W+2)];
  assign w_accSum    = w_accCur + {2'b00, w_sample};
  assign w_avgCntCur = r_avgCnt[2*int'(r_idx) +: 2];
`endif

  // Read sequencer: eoc -> one-cycle den -> wait for drdy or time out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_waitCnt     <= '0;
      r_den         <= 1'b0;
      r_daddr       <= '0;
      r_data        <= '0;
      r_sampleValid <= 1'b0;
      r_sampleCh    <= '0;
      r_err         <= 1'b0;
`ifdef XADC_MON_AVG_EN
      r_acc         <= '0;
      r_avgCnt      <= '0;
`endif
    end else begin
      r_sampleValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (eoc) begin
            r_den   <= 1'b1;
            r_daddr <= CH_ADDR[DRP_ADDR_W*int'(r_idx) +: DRP_ADDR_W];
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_den     <= 1'b0;
          r_waitCnt <= '0;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (drp_drdy) begin
`ifdef XADC_MON_AVG_EN
            if (w_avgCntCur == 2'd3) begin
              r_data[PWM_W*int'(r_idx) +: PWM_W]          <= w_accSum[PWM_W+1:2];
              r_acc[(PWM_W+2)*int'(r_idx) +: (PWM_W+2)]   <= '0;
              r_sampleValid                               <= 1'b1;
              r_sampleCh                                  <= r_idx;
            end else begin
              r_acc[(PWM_W+2)*int'(r_idx) +: (PWM_W+2)]   <= w_accSum;
            end
            r_avgCnt[2*int'(r_idx) +: 2] <= w_avgCntCur + 2'd1;
`else
            r_data[PWM_W*int'(r_idx) +: PWM_W] <= w_sample;
            r_sampleValid                      <= 1'b1;
            r_sampleCh                         <= r_idx;
`endif
            r_idx   <= w_idxNext;
            r_state <= ST_IDLE;
          end else if (r_waitCnt == TMR_LAST) begin
            r_err   <= 1'b1;
            r_idx   <= w_idxNext;
            r_state <= ST_IDLE;
          end else begin
            r_waitCnt <= r_waitCnt + TMR_W'(1);
          end
        end
        default: begin
          r_den   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Free-running PWM period counter shared by all LED channels
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwmCnt <= '0;
    end else begin
      r_pwmCnt <= r_pwmCnt + PWM_W'(1);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_pwm
      pwm_gen #(
        .PWM_W(PWM_W)
      ) u_pwm (
        .clk      (clk),
        .rst      (rst),
        .i_cnt    (r_pwmCnt),
        .i_sample (r_data[g*PWM_W +: PWM_W]),
        .o_led    (led[g])
      );
    end
  endgenerate

  assign drp_den      = r_den;
  assign drp_dwe      = 1'b0;
  assign drp_daddr    = r_daddr;
  assign drp_di       = '0;
  assign data         = r_data;
  assign sample_valid = r_sampleValid;
  assign sample_ch    = r_sampleCh;
  assign err          = r_err;

endmodule
